// File: rtl/clock_sched_pkg.sv
// clock_sched_pkg: shared constants for the clock timer scheduler
package clock_sched_pkg;
  localparam logic [3:0] OFF_MASK        = 4'h0;
  localparam logic [3:0] OFF_PEND        = 4'h1;
  localparam logic [3:0] OFF_ARM         = 4'h2;
  localparam logic [3:0] OFF_RELOAD_BASE = 4'h8;
  localparam logic [3:0] CH_BASE         = 4'h2;
  typedef enum logic {S_POLL = 1'b0, S_RELOAD = 1'b1} state_t;
endpackage

// File: rtl/clock_sched.sv
// clock_sched: CPU passthrough to the clock peripheral plus idle-cycle expiry polling
module clock_sched
  import clock_sched_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  input  logic             cs,
  output logic [WIDTH-1:0] dout,
  output logic [3:0]       m_addr,
  output logic [WIDTH-1:0] m_din,
  output logic             m_wen,
  output logic             m_cs,
  input  logic [WIDTH-1:0] m_dout,
  output logic             irq
);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  logic pass, wr_loc, z, expire, irq_q, irq_d, unused_addr;
  logic [3:0] off;
  state_t state_q, state_d;
  logic [CW-1:0] ch_q, ch_d, ch_nxt;
  logic [NCH-1:0] mask_q, mask_d, pend_q, pend_d, arm_q, arm_d, last_nz_q, last_nz_d, pend_set, w1c;
  logic [WIDTH-1:0] reload_v [NCH];
  logic [WIDTH-1:0] loc_rd;
  assign pass = cs & ~addr[4];
  assign wr_loc = cs & addr[4] & wen;
  assign off = addr[3:0];
  assign unused_addr = ^addr[WIDTH-1:5];
  assign ch_nxt = (ch_q == CW'(NCH - 1)) ? '0 : ch_q + 1'b1;
  assign z = m_dout == '0;
  assign expire = ~pass & (state_q == S_POLL) & last_nz_q[ch_q] & z;
  assign irq = irq_q;
  // The CPU always owns the master port; the FSM only gets the leftover cycles.
  always_comb begin
    m_cs = 1'b1;
    m_addr = pass ? off : CH_BASE + 4'(ch_q);
    m_wen = pass ? wen : (state_q == S_RELOAD);
    m_din = pass ? din : (state_q == S_RELOAD ? reload_v[ch_q] : '0);
  end
  always_comb begin
    loc_rd = '0;
    if (off == OFF_MASK) loc_rd = WIDTH'(mask_q);
    if (off == OFF_PEND) loc_rd = WIDTH'(pend_q);
    if (off == OFF_ARM) loc_rd = WIDTH'(arm_q);
    for (int i = 0; i < NCH; i++)
      if (int'(off) == int'(OFF_RELOAD_BASE) + i) loc_rd = reload_v[i];
  end
  assign dout = pass ? m_dout : (cs ? loc_rd : '0);
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    last_nz_d = last_nz_q;
    pend_set = '0;
    if (pass) begin
      for (int i = 0; i < NCH; i++)
        if (wen && int'(off) == int'(CH_BASE) + i) last_nz_d[i] = |din;
    end else if (state_q == S_POLL) begin
      last_nz_d[ch_q] = ~z;
      pend_set[ch_q] = expire;
      state_d = (expire & arm_q[ch_q]) ? S_RELOAD : S_POLL;
      ch_d = (expire & arm_q[ch_q]) ? ch_q : ch_nxt;
    end else begin
      last_nz_d[ch_q] = |reload_v[ch_q];
      state_d = S_POLL;
      ch_d = ch_nxt;
    end
  end
  // A same-cycle expiry beats the write-1-to-clear.
  always_comb begin
    mask_d = (wr_loc && off == OFF_MASK) ? din[NCH-1:0] : mask_q;
    arm_d = (wr_loc && off == OFF_ARM) ? din[NCH-1:0] : arm_q;
    w1c = (wr_loc && off == OFF_PEND) ? din[NCH-1:0] : '0;
    pend_d = (pend_q & ~w1c) | pend_set;
    irq_d = |(pend_q & mask_q);
  end
  for (genvar i = 0; i < NCH; i++) begin : g_rl
    logic [WIDTH-1:0] rl_q, rl_d;
    always_comb rl_d = (wr_loc && int'(off) == int'(OFF_RELOAD_BASE) + i) ? din : rl_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) rl_q <= '0;
      else rl_q <= rl_d;
    end
    assign reload_v[i] = rl_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_POLL;
      ch_q <= '0;
      mask_q <= '0;
      pend_q <= '0;
      arm_q <= '0;
      last_nz_q <= '0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      mask_q <= mask_d;
      pend_q <= pend_d;
      arm_q <= arm_d;
      last_nz_q <= last_nz_d;
      irq_q <= irq_d;
    end
  end
endmodule
